// File: rtl/arith_scheduler_pkg.sv
// Shared definitions for arith_scheduler: op codes, FSM states, requester count.
package arith_scheduler_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_NEG = 2'b10,
        OP_INC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arith_scheduler_alu.sv
// arith_unit32: 32-bit ripple add unit; S/C = X + Y + cin with op-selected operands.
module arith_unit32
    import arith_scheduler_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [1:0]  op_i,
    output logic [31:0] s_o,
    output logic        c_o
);

    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic [32:0] sum;

    always_comb begin
        x   = 32'd0;
        y   = b_i;
        cin = 1'b1;
        case (op_i)
            OP_ADD: begin
                x   = a_i;
                cin = 1'b0;
            end
            OP_SUB: begin
                x = a_i;
                y = ~b_i;
            end
            OP_NEG:  y = ~b_i;
            default: ;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    end

    assign s_o = sum[31:0];
    assign c_o = sum[32];

endmodule

// File: rtl/arith_scheduler_arb.sv
// rr_arbiter4: first valid requester at or after the pointer wins (one-hot grant).
module rr_arbiter4
    import arith_scheduler_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [1:0]         ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr_i + 2'(i);
            if (!found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arith_scheduler.sv
// Time-shares one arith_unit32 among four requesters. Define ARITH_SCHED_RR_EN
// for round-robin arbitration; otherwise fixed priority (requester 0 highest).
module arith_scheduler
    import arith_scheduler_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req_valid,
    output logic [3:0]   req_ready,
    input  logic [127:0] req_a,
    input  logic [127:0] req_b,
    input  logic [7:0]   req_op,
    output logic [3:0]   rsp_valid,
    input  logic [3:0]   rsp_ready,
    output logic [31:0]  rsp_data,
    output logic         rsp_carry
);

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  owner_q, owner_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] data_q, data_d;
    logic        carry_q, carry_d;
    logic [3:0]  grant;
    logic [1:0]  win_idx;
    logic [31:0] alu_s;
    logic        alu_c;
    logic        rsp_done;

    assign rsp_done = (state_q == RESP) && rsp_ready[owner_q];
    assign win_idx  = onehot_to_idx(grant);

`ifdef ARITH_SCHED_RR_EN
    logic [1:0] ptr_q, ptr_d;

    assign ptr_d = rsp_done ? owner_q + 2'd1 : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 2'd0;
        else        ptr_q <= ptr_d;
    end

    rr_arbiter4 u_arb (.valid_i(req_valid), .ptr_i(ptr_q), .grant_o(grant));
`else
    rr_arbiter4 u_arb (.valid_i(req_valid), .ptr_i(2'd0), .grant_o(grant));
`endif

    // Datapath sees only the latched operands so late request changes cannot disturb it.
    arith_unit32 u_alu (.a_i(a_q), .b_i(b_q), .op_i(op_q), .s_o(alu_s), .c_o(alu_c));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            owner_q <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'd0;
            data_q  <= 32'd0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    owner_d = win_idx;
                    a_d     = req_a[{win_idx, 5'd0} +: 32];
                    b_d     = req_b[{win_idx, 5'd0} +: 32];
                    op_d    = req_op[{win_idx, 1'b0} +: 2];
                    cnt_d   = SETTLE_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    data_d  = alu_s;
                    carry_d = alu_c;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with rst_n keeps req_ready low while reset is held even though the state is IDLE.
    always_comb begin
        req_ready = 4'd0;
        rsp_valid = 4'd0;
        if (state_q == IDLE && rst_n) req_ready = grant;
        if (state_q == RESP)          rsp_valid[owner_q] = 1'b1;
    end

    assign rsp_data  = data_q;
    assign rsp_carry = carry_q;

endmodule

// File: tb/tb_arith_scheduler.sv
// Directed self-checking bench for arith_scheduler (SETTLE_CYCLES=4), both arbitration builds.
module tb_arith_scheduler;
    import arith_scheduler_pkg::*;

    localparam int SETTLE = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [7:0]   req_op;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [31:0]  rsp_data;
    logic         rsp_carry;

    int testsRun    = 0;
    int testsFailed = 0;

    arith_scheduler #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic setReq(input int r, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
        req_op[r*2 +: 2]  = op;
    endtask

    // One full accept/settle/response handshake on requester r.
    task automatic applyStimulus(input int r, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic [31:0] expData, input logic expCarry);
        int         lat;
        logic [3:0] oh;
        oh = 4'b0001 << r;
        @(negedge clk);
        setReq(r, a, b, op);
        req_valid = oh;
        #1;
        checkOutput($sformatf("req_ready r%0d", r), req_ready, oh);
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = 4'd0;
            lat++;
        end while (rsp_valid == 4'd0 && lat < 30);
        checkOutput("latency", lat, SETTLE + 1);
        checkOutput($sformatf("rsp_valid r%0d", r), rsp_valid, oh);
        checkOutput($sformatf("rsp_data r%0d", r), rsp_data, expData);
        checkOutput($sformatf("rsp_carry r%0d", r), rsp_carry, expCarry);
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = 4'd0;
        checkOutput("rsp_valid_drop", rsp_valid, 4'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] expG [5];
        int         nExp;
        int         count;
        int         cyc;
        int         lastCyc;
        int         lat;
        int         badCycles;

        rst_n     = 1'b0;
        req_valid = 4'd0;
        rsp_ready = 4'd0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset req_ready", req_ready, 4'd0);
        checkOutput("reset rsp_valid", rsp_valid, 4'd0);
        checkOutput("reset rsp_data", rsp_data, 32'd0);
        checkOutput("reset rsp_carry", rsp_carry, 1'b0);
        rst_n = 1'b1;

        applyStimulus(0, 32'd30, 32'd16, OP_ADD, 32'd46, 1'b0);
        applyStimulus(1, 32'd5, 32'd7, OP_SUB, 32'hFFFF_FFFE, 1'b0);
        applyStimulus(1, 32'd7, 32'd5, OP_SUB, 32'd2, 1'b1);
        applyStimulus(2, 32'd0, 32'hFFFF_FFFF, OP_INC, 32'd0, 1'b1);
        applyStimulus(2, 32'd0, 32'd1, OP_NEG, 32'hFFFF_FFFF, 1'b0);

        // Owner withholds rsp_ready while a non-owner asserts it and another requester waits.
        @(negedge clk);
        setReq(3, 32'd1, 32'd2, OP_ADD);
        req_valid = 4'b1000;
        #1;
        checkOutput("stall req_ready", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = 4'b0010;
        rsp_ready = 4'b0111;
        lat = 1;
        while (rsp_valid == 4'd0 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("stall latency", lat, SETTLE + 1);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("stall rsp_valid c%0d", i), rsp_valid, 4'b1000);
            checkOutput($sformatf("stall rsp_data c%0d", i), rsp_data, 32'd3);
            checkOutput($sformatf("stall req_ready c%0d", i), req_ready, 4'd0);
            @(negedge clk);
        end
        req_valid = 4'd0;
        rsp_ready = 4'b1000;
        @(negedge clk);
        rsp_ready = 4'd0;
        checkOutput("stall release", rsp_valid, 4'd0);

        // All requesters continuously valid with rsp_ready high.
`ifdef ARITH_SCHED_RR_EN
        expG[0] = 4'b0001; expG[1] = 4'b0010; expG[2] = 4'b0100; expG[3] = 4'b1000; expG[4] = 4'b0001;
        nExp = 5;
`else
        expG[0] = 4'b0001; expG[1] = 4'b0001; expG[2] = 4'b0001; expG[3] = 4'b0001; expG[4] = 4'b0001;
        nExp = 3;
`endif
        @(negedge clk);
        for (int r = 0; r < 4; r++) setReq(r, 32'(r + 1), 32'd0, OP_ADD);
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        count   = 0;
        cyc     = 0;
        lastCyc = 0;
        while (count < nExp && cyc < 100) begin
            #1;
            if (req_ready != 4'd0) begin
                checkOutput($sformatf("grant%0d", count), req_ready, expG[count]);
                if (count > 0) checkOutput($sformatf("grant_gap%0d", count), cyc - lastCyc, SETTLE + 2);
                lastCyc = cyc;
                count++;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("grant_count", count, nExp);
        req_valid = 4'd0;
        repeat (2 * (SETTLE + 2)) @(negedge clk);
        rsp_ready = 4'd0;
        checkOutput("grant drain", rsp_valid, 4'd0);

        // Reset in the middle of SETTLE aborts the operation.
        @(negedge clk);
        setReq(1, 32'd10, 32'd20, OP_ADD);
        req_valid = 4'b0010;
        #1;
        checkOutput("abort req_ready", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'd0;
        @(negedge clk);
        req_valid = 4'b0001;
        rst_n = 1'b0;
        #1;
        checkOutput("abort req_ready", req_ready, 4'd0);
        checkOutput("abort rsp_valid", rsp_valid, 4'd0);
        checkOutput("abort rsp_data", rsp_data, 32'd0);
        checkOutput("abort rsp_carry", rsp_carry, 1'b0);
        @(negedge clk);
        req_valid = 4'd0;
        rst_n = 1'b1;
        badCycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid != 4'd0) badCycles++;
        end
        checkOutput("abort no response", badCycles, 0);
        applyStimulus(1, 32'd100, 32'd200, OP_ADD, 32'd300, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
